spi_controller: RTL and testbench

Bus-side initiator for the board's SPI register interface: accepts one register-write request (7-bit address, 8-bit data) per handshake from the system clock domain and serialises it as a 16-bit SPI mode-0 frame on `cs_n`/`sclk`/`copi`. It is the transmitting end of the link that drives the on-chip SPI peripheral's five output registers (addresses 0x00–0x04) and is used in bench and bring-up to program them.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_clk_div.sv | 32 +++
 rtl/spi_controller.sv | 164 ++++++++++++++++
 tb/tb_spi_controller.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register-write initiator.
package spi_pkg;

  localparam int SPI_FRAME_W = 16;
  localparam int SPI_ADDR_W  = 7;
  localparam int SPI_DATA_W  = 8;
  localparam int SPI_WR_BIT  = 15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period counter: emits a one-cycle tick every CLK_DIV enabled cycles.
module spi_clk_div #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_r;

  assign tick = en && (cnt_r == LAST);

  // Counter restarts on clear and idles at zero while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr || !en) begin
      cnt_r <= '0;
    end else if (cnt_r == LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 register-write initiator (16-bit frame, MSB first).
// Optional read capture on cipo/rdata is enabled by defining SPI_CTRL_CIPO_EN.
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [SPI_ADDR_W-1:0] req_addr,
  input  logic [SPI_DATA_W-1:0] req_data,
`ifdef SPI_CTRL_CIPO_EN
  input  logic                  cipo,
  output logic [SPI_DATA_W-1:0] rdata,
`endif
  output logic                  req_ready,
  output logic                  done,
  output logic                  cs_n,
  output logic                  sclk,
  output logic                  copi
);

  spi_state_e             state_r, state_s;
  logic [SPI_FRAME_W-1:0] frame_r, frame_s;
  logic [3:0]             bit_cnt_r, bit_cnt_s, bit_nxt_s;
  logic                   cs_n_r, cs_n_s, sclk_r, sclk_s, copi_r, copi_s;
  logic                   done_r, done_s;
  logic                   accept_s, tick_s;

  assign accept_s  = req_valid && (state_r == ST_IDLE);
  assign bit_nxt_s = bit_cnt_r - 4'd1;
  assign req_ready = (state_r == ST_IDLE);
  assign cs_n      = cs_n_r;
  assign sclk      = sclk_r;
  assign copi      = copi_r;
  assign done      = done_r;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state_r != ST_IDLE),
    .clr  (accept_s),
    .tick (tick_s)
  );

  // State and registered-output update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      frame_r   <= '0;
      bit_cnt_r <= 4'd0;
      cs_n_r    <= 1'b1;
      sclk_r    <= 1'b0;
      copi_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      frame_r   <= frame_s;
      bit_cnt_r <= bit_cnt_s;
      cs_n_r    <= cs_n_s;
      sclk_r    <= sclk_s;
      copi_r    <= copi_s;
      done_r    <= done_s;
    end
  end

  // Next-state and next-output logic; everything advances on half-period ticks.
  always_comb begin
    state_s   = state_r;
    frame_s   = frame_r;
    bit_cnt_s = bit_cnt_r;
    cs_n_s    = cs_n_r;
    sclk_s    = sclk_r;
    copi_s    = copi_r;
    done_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s   = ST_SETUP;
          frame_s   = {1'b1, req_addr, req_data};
          bit_cnt_s = 4'd15;
          cs_n_s    = 1'b0;
          copi_s    = frame_s[SPI_WR_BIT];
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (tick_s) begin
          state_s = ST_SHIFT;
          sclk_s  = 1'b1;
        end else begin
          state_s = ST_SETUP;
        end
      end
      ST_SHIFT: begin
        if (tick_s && sclk_r) begin
          sclk_s = 1'b0;
          if (bit_cnt_r == 4'd0) begin
            copi_s  = 1'b0;
            state_s = ST_HOLD;
          end else begin
            copi_s    = frame_r[bit_nxt_s];
            bit_cnt_s = bit_nxt_s;
          end
        end else if (tick_s) begin
          sclk_s = 1'b1;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_HOLD: begin
        if (tick_s) begin
          state_s = ST_GAP;
          cs_n_s  = 1'b1;
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_GAP: begin
        if (tick_s) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = ST_GAP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cs_n_s  = 1'b1;
        sclk_s  = 1'b0;
        copi_s  = 1'b0;
      end
    endcase
  end

`ifdef SPI_CTRL_CIPO_EN
  logic [SPI_FRAME_W-1:0] rx_r;
  logic [SPI_DATA_W-1:0]  rdata_r;

  assign rdata = rdata_r;

  // Sample cipo at the end of each sclk high phase; publish the low byte at frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_r    <= '0;
      rdata_r <= '0;
    end else begin
      if (state_r == ST_SHIFT && tick_s && sclk_r) begin
        rx_r <= {rx_r[SPI_FRAME_W-2:0], cipo};
      end else begin
        rx_r <= rx_r;
      end
      if (state_r == ST_GAP && tick_s) begin
        rdata_r <= rx_r[SPI_DATA_W-1:0];
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end
`endif

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench: timing model of the frame plus a behavioural SPI receiver.
module tb_spi_controller;
  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [6:0] req_addr = 7'd0;
  logic [7:0] req_data = 8'd0;
  logic       req_ready, done, cs_n, sclk, copi;
`ifdef SPI_CTRL_CIPO_EN
  logic       cipo = 1'b0;
  logic [7:0] rdata;
  logic [15:0] cipo_pat = 16'h00C3;
`endif

  spi_controller #(.CLK_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data),
`ifdef SPI_CTRL_CIPO_EN
    .cipo(cipo), .rdata(rdata),
`endif
    .req_ready(req_ready), .done(done), .cs_n(cs_n), .sclk(sclk), .copi(copi)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Model state: offset of the current cycle from the acceptance edge.
  bit          m_busy = 1'b0;
  int          m_o = 0;
  int          mj, mf;
  logic [15:0] m_frame = 16'h0;
  logic        e_cs, e_sclk, e_copi, e_done, e_rdy;
  int          acc_cyc = 0, done_cyc = 0;

  // Receiver model
  logic [15:0] rx_sh = 16'h0;
  int          rx_cnt = 0;
  logic [7:0]  regs [128];
  int          frames = 0, rises = 0;
  logic        p_sclk = 1'b0, p_cs = 1'b1;
  int          cs_high_run = 0, last_gap = 0;

  initial for (int i = 0; i < 128; i++) regs[i] = 8'h00;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_busy = 1'b0;
    end else if (req_valid && (!m_busy || m_o == 34*D)) begin
      m_busy = 1'b1; m_o = 0; m_frame = {1'b1, req_addr, req_data}; acc_cyc = cyc;
    end else if (m_busy) begin
      m_o++;
      if (m_o > 34*D) m_busy = 1'b0;
    end
    #1;
    if (m_busy && m_o < 34*D) begin
      mj = m_o / D;
      mf = mj / 2;
      e_cs   = (m_o < 33*D) ? 1'b0 : 1'b1;
      e_sclk = (mj >= 1 && mj <= 31 && (mj % 2) == 1);
      e_copi = (mf >= 16) ? 1'b0 : m_frame[15-mf];
      e_done = 1'b0;
      e_rdy  = 1'b0;
    end else begin
      e_cs = 1'b1; e_sclk = 1'b0; e_copi = 1'b0;
      e_done = m_busy && (m_o == 34*D);
      e_rdy  = 1'b1;
    end
    chk("cs_n", cs_n, e_cs);
    chk("sclk", sclk, e_sclk);
    chk("copi", copi, e_copi);
    chk("done", done, e_done);
    chk("req_ready", req_ready, e_rdy);

    if (!rst_n) begin
      rx_cnt = 0;
    end else begin
      if (sclk && !p_sclk && !cs_n) begin
        rx_sh = {rx_sh[14:0], copi};
        rx_cnt++;
        rises++;
      end
      if (cs_n && !p_cs) begin
        if (rx_cnt == 16 && rx_sh[15]) begin
          regs[rx_sh[14:8]] = rx_sh[7:0];
          frames++;
        end
        rx_cnt = 0;
      end
      if (done) done_cyc = cyc;
    end
    if (cs_n && !p_cs) cs_high_run = 0;
    if (cs_n) cs_high_run++;
    if (!cs_n && p_cs) last_gap = cs_high_run;
    p_sclk = sclk;
    p_cs = cs_n;
  end

`ifdef SPI_CTRL_CIPO_EN
  always @(negedge clk) begin
    if (!sclk) cipo = (rx_cnt < 16) ? cipo_pat[15-rx_cnt] : 1'b0;
  end
`endif

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=busy expected=ready cycle=%0d", cyc);
    end
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    req_addr = a; req_data = d; req_valid = 1'b1;
    wait_ready();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=0 expected=1 cycle=%0d", cyc);
    end
  endtask

  int f0, r0;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_copi", copi, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ready", req_ready, 1'b1);
`ifdef SPI_CTRL_CIPO_EN
    chk("rst_rdata", rdata, 8'h00);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single write 0x02 = 0xA5
    r0 = rises;
    do_write(7'h02, 8'hA5);
    wait_done();
    chk("done_latency", done_cyc - acc_cyc, 32'd272);
    chk("copi_bits", rx_sh, 16'h82A5);
    chk("rise_count", rises - r0, 32'd16);
    chk("reg2", regs[2], 8'hA5);

    // Request changes mid-frame must be ignored
    f0 = frames;
    do_write(7'h03, 8'h5A);
    repeat (5*D) @(negedge clk);
    req_addr = 7'h7F; req_data = 8'hFF; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    wait_done();
    repeat (40*D) @(negedge clk);
    chk("ignored_frames", frames - f0, 32'd1);
    chk("reg3", regs[3], 8'h5A);
    chk("reg7f", regs[127], 8'h00);

    // Back-to-back with req_valid held high
    @(negedge clk);
    req_addr = 7'h00; req_data = 8'h11; req_valid = 1'b1;
    wait_ready();
    @(negedge clk);
    req_addr = 7'h01; req_data = 8'h22;
    wait_ready();
    chk("b2b_on_done", done, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    wait_done();
    chk("reg0", regs[0], 8'h11);
    chk("reg1", regs[1], 8'h22);
    chk("cs_gap", last_gap, 32'd9);

    // Reset mid-frame, then recover
    @(negedge clk);
    req_addr = 7'h05; req_data = 8'h77; req_valid = 1'b1;
    wait_ready();
    @(negedge clk);
    req_valid = 1'b0;
    repeat (10*D - 1) @(negedge clk);
    chk("pre_rst_cs_n", cs_n, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cs_n", cs_n, 1'b1);
    chk("mid_rst_sclk", sclk, 1'b0);
    chk("mid_rst_copi", copi, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1'b1);
    chk("reg5_abandoned", regs[5], 8'h00);
    do_write(7'h04, 8'h0F);
    wait_done();
    chk("reg4", regs[4], 8'h0F);

`ifdef SPI_CTRL_CIPO_EN
    do_write(7'h00, 8'h33);
    wait_done();
    chk("rdata_done", rdata, 8'hC3);
    repeat (20) @(negedge clk);
    chk("rdata_held", rdata, 8'hC3);
`endif

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
